// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock supervisor with staggered release of downstream resets
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_RESETS     = 3,
    parameter int STAGGER        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  ready,
    output logic [7:0]            lock_loss_cnt,
    output logic [7:0]            timeout_cnt
);
    localparam int M1   = LOCK_TIMEOUT > STABLE_CYCLES ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int M2   = PLL_RST_CYCLES > STAGGER * NUM_RESETS ? PLL_RST_CYCLES : STAGGER * NUM_RESETS;
    localparam int MAXV = M1 > M2 ? M1 : M2;
    localparam int CW   = $clog2(MAXV);
    typedef enum logic [2:0] {S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN} state_t;
    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [NUM_RESETS-1:0]   rst_out_nx;
    logic [7:0]              loss_nx, tmo_nx;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    lock_s;
    assign lock_s = sync[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_PLL_RST;
            cnt           <= '0;
            sync          <= '0;
            rst_out       <= '1;
            pll_rst       <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            sync          <= {sync[SYNC_STAGES-2:0], pll_locked};
            rst_out       <= rst_out_nx;
            pll_rst       <= state_nx == S_PLL_RST;
            ready         <= state_nx == S_RUN;
            lock_loss_cnt <= loss_nx;
            timeout_cnt   <= tmo_nx;
        end
    end
    // Release shifts a zero in from bit 0 so bits can only fall in ascending order.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        rst_out_nx = rst_out;
        loss_nx    = lock_loss_cnt;
        tmo_nx     = timeout_cnt;
        unique case (state)
            S_PLL_RST: begin
                if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
                    state_nx = S_WAIT_LOCK;
                    cnt_nx   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = S_STABLE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_nx = S_PLL_RST;
                    cnt_nx   = '0;
                    tmo_nx   = timeout_cnt + {7'd0, timeout_cnt != 8'hff};
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_nx = S_WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    cnt_nx     = '0;
                    rst_out_nx = rst_out << 1;
                    state_nx   = rst_out_nx == '0 ? S_RUN : S_RELEASE;
                end
            end
            S_RELEASE, S_RUN: begin
                if (!lock_s) begin
                    state_nx   = S_PLL_RST;
                    cnt_nx     = '0;
                    rst_out_nx = '1;
                    loss_nx    = lock_loss_cnt + {7'd0, lock_loss_cnt != 8'hff};
                end else if (state == S_RUN) begin
                    cnt_nx = '0;
                end else if (cnt == CW'(STAGGER - 1)) begin
                    cnt_nx     = '0;
                    rst_out_nx = rst_out << 1;
                    state_nx   = rst_out_nx == '0 ? S_RUN : S_RELEASE;
                end
            end
            default: begin
                state_nx   = S_PLL_RST;
                cnt_nx     = '0;
                rst_out_nx = '1;
            end
        endcase
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scenario tasks with a queue of expected output events
module tb_pll_reset_sequencer;
    logic       clk = 1'b0, rst = 1'b1, pll_locked = 1'b0;
    logic       pll_rst, ready;
    logic [2:0] rst_out;
    logic [7:0] lock_loss_cnt, timeout_cnt;
    int cyc = 0, highs = 0, n_cmp = 0, n_bad = 0;
    typedef struct {int t; logic [7:0] v;} exp_t;
    exp_t q[$];

    pll_reset_sequencer #(
        .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32),
        .STABLE_CYCLES(8), .NUM_RESETS(3), .STAGGER(2)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
        .rst_out(rst_out), .ready(ready), .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (pll_rst) highs <= highs + 1;

    task automatic wait_out_change(input int bound, output int t);
        logic [3:0] p;
        p = {rst_out, ready};
        t = -1;
        for (int i = 0; i < bound && t < 0; i++) begin
            @(negedge clk);
            if ({rst_out, ready} !== p) t = cyc;
        end
    endtask

    task automatic wait_pll_rst(input logic v, input int bound, output int t);
        t = (pll_rst === v) ? cyc : -1;
        for (int i = 0; i < bound && t < 0; i++) begin
            @(negedge clk);
            if (pll_rst === v) t = cyc;
        end
    endtask

    task automatic test_reset;
        int r, t;
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
        n_cmp++; if (rst_out !== 3'b111) begin n_bad++; $display("FAIL reset_rst_out: got %b want 111", rst_out); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (lock_loss_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", lock_loss_cnt, timeout_cnt); end
        rst = 1'b0;
        r = cyc;
        wait_pll_rst(1'b0, 10, t);
        n_cmp++; if (t !== r + 4) begin n_bad++; $display("FAIL reset_pll_rst_len: got fall at %0d want %0d", t, r + 4); end
    endtask

    task automatic test_bringup(input string tag);
        int tf, t;
        exp_t e;
        wait_pll_rst(1'b0, 20, tf);
        n_cmp++; if (tf < 0) begin n_bad++; $display("FAIL %s_pll_rst_fall: got none want fall within 20", tag); end
        while (cyc < tf + 10) @(negedge clk);
        pll_locked = 1'b1;
        e = '{t: cyc + 11, v: 8'h0C}; q.push_back(e);
        e = '{t: cyc + 13, v: 8'h08}; q.push_back(e);
        e = '{t: cyc + 15, v: 8'h01}; q.push_back(e);
        repeat (3) begin
            wait_out_change(30, t);
            e = q.pop_front();
            n_cmp++;
            if (t !== e.t || {4'b0, rst_out, ready} !== e.v) begin
                n_bad++;
                $display("FAIL %s_release: got cyc=%0d out/ready=%b want cyc=%0d out/ready=%b", tag, t, {rst_out, ready}, e.t, e.v[3:0]);
            end
        end
    endtask

    task automatic test_loss_in_run;
        int t;
        exp_t e;
        pll_locked = 1'b0;
        e = '{t: cyc + 3, v: 8'h0E}; q.push_back(e);
        wait_out_change(10, t);
        e = q.pop_front();
        n_cmp++; if (t !== e.t || {4'b0, rst_out, ready} !== e.v) begin n_bad++; $display("FAIL loss_reassert: got cyc=%0d out/ready=%b want cyc=%0d out/ready=%b", t, {rst_out, ready}, e.t, e.v[3:0]); end
        n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL loss_pll_rst: got %b want 1", pll_rst); end
        n_cmp++; if (lock_loss_cnt !== 8'd1) begin n_bad++; $display("FAIL loss_cnt: got %0d want 1", lock_loss_cnt); end
        test_bringup("relock");
    endtask

    task automatic test_timeout;
        int tr, tf;
        exp_t e;
        pll_locked = 1'b0;
        wait_pll_rst(1'b1, 10, tr);
        wait_pll_rst(1'b0, 10, tf);
        for (int n = 1; n <= 3; n++) begin
            e = '{t: tf + 32, v: 8'(n)}; q.push_back(e);
            wait_pll_rst(1'b1, 45, tr);
            e = q.pop_front();
            n_cmp++; if (tr !== e.t || timeout_cnt !== e.v) begin n_bad++; $display("FAIL timeout_%0d: got cyc=%0d cnt=%0d want cyc=%0d cnt=%0d", n, tr, timeout_cnt, e.t, e.v); end
            n_cmp++; if (rst_out !== 3'b111 || ready !== 1'b0) begin n_bad++; $display("FAIL timeout_hold_%0d: got %b/%b want 111/0", n, rst_out, ready); end
            wait_pll_rst(1'b0, 10, tf);
            n_cmp++; if (tf - tr !== 4) begin n_bad++; $display("FAIL timeout_pulse_%0d: got %0d want 4", n, tf - tr); end
        end
        n_cmp++; if (lock_loss_cnt !== 8'd2) begin n_bad++; $display("FAIL timeout_loss_cnt: got %0d want 2", lock_loss_cnt); end
    endtask

    task automatic test_unstable;
        int tf, t, h0;
        exp_t e;
        wait_pll_rst(1'b0, 10, tf);
        h0 = highs;
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        e = '{t: cyc + 11, v: 8'h0C}; q.push_back(e);
        e = '{t: cyc + 13, v: 8'h08}; q.push_back(e);
        e = '{t: cyc + 15, v: 8'h01}; q.push_back(e);
        repeat (3) begin
            wait_out_change(30, t);
            e = q.pop_front();
            n_cmp++;
            if (t !== e.t || {4'b0, rst_out, ready} !== e.v) begin
                n_bad++;
                $display("FAIL unstable_release: got cyc=%0d out/ready=%b want cyc=%0d out/ready=%b", t, {rst_out, ready}, e.t, e.v[3:0]);
            end
        end
        n_cmp++; if (highs !== h0) begin n_bad++; $display("FAIL unstable_no_pll_rst: got %0d high cycles want 0", highs - h0); end
        n_cmp++; if (timeout_cnt !== 8'd3) begin n_bad++; $display("FAIL unstable_timeout_cnt: got %0d want 3", timeout_cnt); end
    endtask

    task automatic test_saturation_and_midop_reset;
        int rises, tf, t, r;
        logic prev;
        rises = 0;
        prev = pll_rst;
        pll_locked = 1'b0;
        for (int i = 0; i < 12000 && rises < 301; i++) begin
            @(negedge clk);
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
        end
        n_cmp++; if (rises !== 301) begin n_bad++; $display("FAIL sat_pulses: got %0d want 301", rises); end
        n_cmp++; if (timeout_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_timeout_cnt: got %0d want 255", timeout_cnt); end
        n_cmp++; if (lock_loss_cnt !== 8'd3) begin n_bad++; $display("FAIL sat_loss_cnt: got %0d want 3", lock_loss_cnt); end
        wait_pll_rst(1'b0, 10, tf);
        pll_locked = 1'b1;
        wait_out_change(30, t);
        n_cmp++; if (t !== tf + 11 || rst_out !== 3'b110) begin n_bad++; $display("FAIL midop_release: got cyc=%0d out=%b want cyc=%0d out=110", t, rst_out, tf + 11); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rst_out !== 3'b111 || ready !== 1'b0 || pll_rst !== 1'b1) begin n_bad++; $display("FAIL midop_outputs: got %b/%b/%b want 111/0/1", rst_out, ready, pll_rst); end
        n_cmp++; if (lock_loss_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin n_bad++; $display("FAIL midop_counts: got %0d/%0d want 0/0", lock_loss_cnt, timeout_cnt); end
        rst = 1'b0;
        r = cyc;
        wait_pll_rst(1'b0, 10, t);
        n_cmp++; if (t !== r + 4) begin n_bad++; $display("FAIL midop_pll_rst_len: got fall at %0d want %0d", t, r + 4); end
    endtask

    initial begin
        test_reset();
        test_bringup("bringup");
        test_loss_in_run();
        test_timeout();
        test_unstable();
        test_saturation_and_midop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1000000");
        $fatal(1);
    end
endmodule
